// File: rtl/fp_mul.sv
// fp_mul: multi-cycle IEEE 754 binary32 multiplier, subnormals flushed to zero, 4 rounding modes.
// Latency: start sampled at edge k in IDLE -> o_result/o_done updated at edge k+4 (5-cycle issue rate).
// Backpressure: none; i_start is ignored while busy, o_done is a one-cycle pulse, o_result holds.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, asynchronous active-high reset
//   i_start               request pulse, only honoured in IDLE
//   i_a, i_b              binary32 operands, latched on the accepted start edge
//   i_round_mode          00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
//   o_result              product, valid with o_done and held until the next completion
//   o_done                one-cycle completion pulse
module fp_mul #(
  parameter int D_LEN = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [D_LEN-1:0] i_a,
  input  logic [D_LEN-1:0] i_b,
  input  logic [1:0]       i_round_mode,
  output logic [D_LEN-1:0] o_result,
  output logic             o_done
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND} state_t;

  state_t r_state, w_next;

  // Latched request
  logic [31:0] r_a, r_b;
  logic [1:0]  r_rm;
  // Unpack stage
  logic        r_sign, r_special;
  logic [31:0] r_spec_val;
  logic [23:0] r_ma, r_mb;
  logic [7:0]  r_ea, r_eb;
  // Multiply / normalize stages
  logic [47:0] r_prod;
  logic signed [9:0] r_exp;
  logic [22:0] r_sig;
  logic        r_guard, r_sticky;
  // Outputs
  logic [31:0] r_result;
  logic        r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_UNPACK;
      S_UNPACK: w_next = S_MUL;
      S_MUL:    w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand classification (exp=0 counts as zero regardless of mantissa)
  logic [7:0] w_ea, w_eb;
  logic       w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_sign;
  logic       w_special;
  logic [31:0] w_spec_val;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_zero_a = (w_ea == 8'h00);
  assign w_zero_b = (w_eb == 8'h00);
  assign w_inf_a  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_inf_b  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_nan_a  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_nan_b  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);

  // Priority order matters: NaN beats Inf*0 beats Inf beats zero
  always_comb begin
    w_special  = 1'b1;
    w_spec_val = 32'h7FC00000;
    if (w_nan_a || w_nan_b)                                w_spec_val = 32'h7FC00000;
    else if ((w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) w_spec_val = 32'h7FC00000;
    else if (w_inf_a || w_inf_b)                           w_spec_val = {w_sign, 8'hFF, 23'd0};
    else if (w_zero_a || w_zero_b)                         w_spec_val = {w_sign, 31'd0};
    else                                                   w_special  = 1'b0;
  end

  // Rounding and packing
  logic        w_inc;
  logic [23:0] w_rnd;
  logic signed [9:0] w_exp_fin;
  logic [31:0] w_packed;

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      2'b00: w_inc = r_guard & (r_sticky | r_sig[0]);
      2'b01: w_inc = 1'b0;
      2'b10: w_inc = (r_guard | r_sticky) & ~r_sign;
      2'b11: w_inc = (r_guard | r_sticky) & r_sign;
      default: w_inc = 1'b0;
    endcase
  end

  // A carry out of the 23-bit mantissa leaves w_rnd[22:0]=0 and bumps the exponent
  assign w_rnd     = {1'b0, r_sig} + {23'd0, w_inc};
  assign w_exp_fin = r_exp + $signed({9'd0, w_rnd[23]});

  always_comb begin
    w_packed = {r_sign, w_exp_fin[7:0], w_rnd[22:0]};
    if (r_special) begin
      w_packed = r_spec_val;
    end else if (w_exp_fin >= 10'sd255) begin
      // Overflow goes to Inf only when the rounding direction points away from zero
      case (r_rm)
        2'b00:   w_packed = {r_sign, 8'hFF, 23'd0};
        2'b01:   w_packed = {r_sign, 8'hFE, 23'h7FFFFF};
        2'b10:   w_packed = r_sign ? 32'hFF7FFFFF : 32'h7F800000;
        default: w_packed = r_sign ? 32'hFF800000 : 32'h7F7FFFFF;
      endcase
    end else if (w_exp_fin <= 10'sd0) begin
      w_packed = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_rm       <= '0;
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_ea       <= '0;
      r_eb       <= '0;
      r_prod     <= '0;
      r_exp      <= '0;
      r_sig      <= '0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a  <= i_a[31:0];
            r_b  <= i_b[31:0];
            r_rm <= i_round_mode;
          end
        end
        S_UNPACK: begin
          r_sign     <= w_sign;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_ea       <= w_ea;
          r_eb       <= w_eb;
          r_ma       <= {1'b1, r_a[22:0]};
          r_mb       <= {1'b1, r_b[22:0]};
        end
        S_MUL: begin
          r_prod <= {24'd0, r_ma} * {24'd0, r_mb};
          r_exp  <= $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127;
        end
        S_NORM: begin
          if (r_prod[47]) begin
            r_sig    <= r_prod[46:24];
            r_exp    <= r_exp + 10'sd1;
            r_guard  <= r_prod[23];
            r_sticky <= |r_prod[22:0];
          end else begin
            r_sig    <= r_prod[45:23];
            r_guard  <= r_prod[22];
            r_sticky <= |r_prod[21:0];
          end
        end
        S_ROUND: begin
          r_result <= w_packed;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_result = {{(D_LEN-32){1'b0}}, r_result};
  assign o_done   = r_done;

endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: directed-vector bench for fp_mul with hand-computed expected products.
// Latency: each operation is checked edge by edge from the start edge to one cycle past done.
// Backpressure: none; busy-start and mid-operation reset behaviour are exercised directly.
module tb_fp_mul;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [1:0]  i_round_mode = '0;
  logic [31:0] o_result;
  logic        o_done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cnt0;

  fp_mul #(.D_LEN(32)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_round_mode (i_round_mode),
    .o_result     (o_result),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  // done is high for a whole cycle, so each pulse spans exactly one falling edge
  always @(negedge i_clk) if (o_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation with a single-cycle start, scramble the inputs right after
  // the start edge, then check done timing, the result and the pulse count.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] exp);
    int c;
    @(negedge i_clk);
    i_a = a; i_b = b; i_round_mode = rm; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    c = done_cnt;
    i_start = 1'b0;
    i_a = $urandom; i_b = $urandom; i_round_mode = 2'($urandom_range(0, 3));
    repeat (3) begin
      @(posedge i_clk); #1;
      check({tag, " early_done"}, {31'd0, o_done}, 32'd0);
    end
    @(posedge i_clk); #1;
    check({tag, " done"}, {31'd0, o_done}, 32'd1);
    check({tag, " result"}, o_result, exp);
    @(posedge i_clk); #1;
    check({tag, " done_drop"}, {31'd0, o_done}, 32'd0);
    check({tag, " result_hold"}, o_result, exp);
    check({tag, " pulses"}, done_cnt, c + 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("reset result", o_result, 32'h0);
    check("reset done", {31'd0, o_done}, 32'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);

    // Basic latency and normal path
    run_op("1x2",        32'h3F800000, 32'h40000000, 2'b00, 32'h40000000);
    run_op("1.5x1.5",    32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40100000);
    run_op("-3x0.5",     32'hC0400000, 32'h3F000000, 2'b00, 32'hBFC00000);

    // Specials
    run_op("inf_x_0",    32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000);
    run_op("-inf_x_2",   32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000);
    run_op("-0_x_1",     32'h80000000, 32'h3F800000, 2'b00, 32'h80000000);
    run_op("subn_x_1",   32'h00000001, 32'h3F800000, 2'b00, 32'h00000000);
    run_op("nan_x_1",    32'h7FC00001, 32'h3F800000, 2'b01, 32'h7FC00000);
    run_op("underflow",  32'h00800000, 32'h00800000, 2'b10, 32'h00000000);

    // Overflow by mode
    run_op("ovf_rne",    32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000);
    run_op("ovf_rtz",    32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF);
    run_op("ovf_pinf",   32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000);
    run_op("ovf_minf",   32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F7FFFFF);
    run_op("novf_pinf",  32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF7FFFFF);
    run_op("novf_minf",  32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF800000);

    // Rounding by mode: P = 2^46 + 2^24 + 1 -> guard 0, sticky 1
    run_op("rnd_rne",    32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002);
    run_op("rnd_pinf",   32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003);
    run_op("rnd_rtz",    32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002);
    run_op("rnd_minf",   32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002);
    // P = 2^47 - 2: all-ones mantissa, guard 1 -> RNE carries into the exponent
    run_op("carry_rne",  32'h3FFFFFFE, 32'h3F800001, 2'b00, 32'h40000000);
    run_op("carry_rtz",  32'h3FFFFFFE, 32'h3F800001, 2'b01, 32'h3FFFFFFF);
    run_op("neg_carry_minf", 32'hBFFFFFFE, 32'h3F800001, 2'b11, 32'hC0000000);

    // Start pulses while busy are ignored
    @(negedge i_clk);
    i_a = 32'h3F800000; i_b = 32'h40000000; i_round_mode = 2'b00; i_start = 1'b1;
    @(posedge i_clk); #1;
    cnt0 = done_cnt;
    i_a = 32'h7F800000; i_b = 32'h00000000;
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    check("busy done", {31'd0, o_done}, 32'd1);
    check("busy result", o_result, 32'h40000000);
    repeat (6) @(posedge i_clk);
    #1;
    check("busy pulses", done_cnt, cnt0 + 1);

    // Start held high across done relaunches on the cycle after done
    @(negedge i_clk);
    i_a = 32'h3F800000; i_b = 32'h40000000; i_round_mode = 2'b00; i_start = 1'b1;
    @(posedge i_clk); #1;
    repeat (4) @(posedge i_clk);
    #1;
    check("held done1", {31'd0, o_done}, 32'd1);
    check("held result1", o_result, 32'h40000000);
    i_a = 32'h3FC00000; i_b = 32'h3FC00000;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("held gap", {31'd0, o_done}, 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    check("held early", {31'd0, o_done}, 32'd0);
    @(posedge i_clk); #1;
    check("held done2", {31'd0, o_done}, 32'd1);
    check("held result2", o_result, 32'h40100000);

    // Reset two cycles after start aborts the operation
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_a = 32'h40400000; i_b = 32'h40400000; i_round_mode = 2'b00; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cnt0 = done_cnt;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("abort result", o_result, 32'h0);
    repeat (6) @(posedge i_clk);
    #1;
    check("abort no_done", done_cnt, cnt0);
    check("abort result_after", o_result, 32'h0);
    run_op("after_abort", 32'h40400000, 32'h40400000, 2'b00, 32'h41100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
